// File: rtl/mmul_parallel_cfg_master_if.sv
// Peripheral control bus between a configuration initiator and the
// mmul_parallel HWPE peripheral slave port.
interface mmul_parallel_cfg_master_if #(
  parameter int unsigned ID_WIDTH = 10
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic [31:0]         r_data;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/mmul_parallel_cfg_master.sv
// Offloads one job to the mmul_parallel HWPE: acquire a job slot (with
// back-off and bounded retries), write the job registers, trigger, then wait
// for the end-of-job event. One bus transaction outstanding at a time; every
// write response is awaited like a read response.
module mmul_parallel_cfg_master #(
  parameter int unsigned N_PARAMS  = 8,
  parameter int unsigned ID_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] REG_OFFS  = 32'h40,
  parameter int unsigned BACKOFF   = 16,
  parameter int unsigned MAX_RETRY = 255,
  parameter int unsigned MASTER_ID = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [N_PARAMS-1:0][31:0] params_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [7:0]               job_id_o,
  input  logic                     evt_i,
  mmul_parallel_cfg_master_if.master periph
);

  localparam int unsigned IDX_W = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;
  localparam int unsigned BO_W  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam int unsigned RC_W  = $clog2(MAX_RETRY + 1);

  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_PARAMS - 1);
  localparam logic [BO_W-1:0]     BO_LAST   = BO_W'(BACKOFF - 1);
  localparam logic [RC_W-1:0]     RC_MAX    = RC_W'(MAX_RETRY);
  localparam logic [31:0]         ACQ_ADDR  = BASE_ADDR + 32'h4;
  localparam logic [31:0]         TRIG_ADDR = BASE_ADDR;
  localparam logic [ID_WIDTH-1:0] MY_ID     = ID_WIDTH'(MASTER_ID);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACQ_REQ,
    ST_ACQ_RSP,
    ST_BACKOFF,
    ST_WR_REQ,
    ST_WR_RSP,
    ST_TRIG_REQ,
    ST_TRIG_RSP,
    ST_WAIT_EVT,
    ST_DONE
  } state_t;

  state_t                     state;
  logic [N_PARAMS-1:0][31:0]  params_q;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           idx_nxt;
  logic [RC_W-1:0]            retry_cnt;
  logic [RC_W-1:0]            retry_nxt;
  logic [BO_W-1:0]            bo_cnt;
  logic                       evt_seen;
  logic                       id_err;
  logic                       unused_rdata;

  // Job register i lives at BASE_ADDR + REG_OFFS + 4*i (modulo 2^32).
  function automatic logic [31:0] reg_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + REG_OFFS + (32'(i) << 2);
  endfunction

  assign idx_nxt      = idx + 1'b1;
  assign retry_nxt    = retry_cnt + 1'b1;
  assign id_err       = periph.r_valid && (periph.r_id != MY_ID);
  assign unused_rdata = ^periph.r_data[30:8];

  assign busy_o    = (state != ST_IDLE);
  assign periph.be = 4'hF;
  assign periph.id = MY_ID;

  // Capture the job parameters in the accepted start cycle only.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && start_i) params_q <= params_i;
  end

  // Job sequencer: control state plus registered bus address phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      periph.req  <= 1'b0;
      periph.add  <= 32'h0;
      periph.wen  <= 1'b1;
      periph.data <= 32'h0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      job_id_o    <= 8'h0;
      idx         <= '0;
      retry_cnt   <= '0;
      bo_cnt      <= '0;
      evt_seen    <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      // Remember an event that arrives before WAIT_EVT is reached.
      if (evt_i && (state == ST_TRIG_REQ || state == ST_TRIG_RSP ||
                    state == ST_WAIT_EVT)) begin
        evt_seen <= 1'b1;
      end
      if (id_err) begin
        // Response not addressed to us: abandon the job, slot stays taken.
        error_o    <= 1'b1;
        periph.req <= 1'b0;
        state      <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_i) begin
              retry_cnt   <= '0;
              evt_seen    <= 1'b0;
              periph.req  <= 1'b1;
              periph.add  <= ACQ_ADDR;
              periph.wen  <= 1'b1;
              periph.data <= 32'h0;
              state       <= ST_ACQ_REQ;
            end
          end
          ST_ACQ_REQ: begin
            if (periph.gnt) begin
              periph.req <= 1'b0;
              state      <= ST_ACQ_RSP;
            end
          end
          ST_ACQ_RSP: begin
            if (periph.r_valid) begin
              if (periph.r_data[31]) begin
                if (retry_nxt == RC_MAX) begin
                  error_o <= 1'b1;
                  state   <= ST_IDLE;
                end else begin
                  retry_cnt <= retry_nxt;
                  bo_cnt    <= '0;
                  state     <= ST_BACKOFF;
                end
              end else begin
                job_id_o    <= periph.r_data[7:0];
                idx         <= '0;
                periph.req  <= 1'b1;
                periph.add  <= reg_addr('0);
                periph.wen  <= 1'b0;
                periph.data <= params_q[0];
                state       <= ST_WR_REQ;
              end
            end
          end
          ST_BACKOFF: begin
            if (bo_cnt == BO_LAST) begin
              periph.req  <= 1'b1;
              periph.add  <= ACQ_ADDR;
              periph.wen  <= 1'b1;
              periph.data <= 32'h0;
              state       <= ST_ACQ_REQ;
            end else begin
              bo_cnt <= bo_cnt + 1'b1;
            end
          end
          ST_WR_REQ: begin
            if (periph.gnt) begin
              periph.req <= 1'b0;
              state      <= ST_WR_RSP;
            end
          end
          ST_WR_RSP: begin
            if (periph.r_valid) begin
              periph.req <= 1'b1;
              periph.wen <= 1'b0;
              if (idx == LAST_IDX) begin
                periph.add  <= TRIG_ADDR;
                periph.data <= 32'h0;
                state       <= ST_TRIG_REQ;
              end else begin
                idx         <= idx_nxt;
                periph.add  <= reg_addr(idx_nxt);
                periph.data <= params_q[idx_nxt];
                state       <= ST_WR_REQ;
              end
            end
          end
          ST_TRIG_REQ: begin
            if (periph.gnt) begin
              periph.req <= 1'b0;
              state      <= ST_TRIG_RSP;
            end
          end
          ST_TRIG_RSP: begin
            if (periph.r_valid) state <= ST_WAIT_EVT;
          end
          ST_WAIT_EVT: begin
            if (evt_i || evt_seen) state <= ST_DONE;
          end
          ST_DONE: begin
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mmul_parallel_cfg_master.md
# mmul_parallel_cfg_master

Peripheral-bus initiator that offloads one job to the mmul_parallel HWPE. On `start_i` it acquires a job slot through the HWPE peripheral control port, writes N_PARAMS job registers, writes TRIGGER, waits for the completion event and then reports done. It sits between a host-side sequencer or testbench and the HWPE periph slave port, and drives the master side of that protocol.

## Interface
- N_PARAMS, 8, number of 32-bit job registers written per job
- ID_WIDTH, 10, width of periph_id_o / periph_r_id_i
- BASE_ADDR, 32'h0000_0000, HWPE peripheral base address
- REG_OFFS, 32'h40, byte offset of job register 0; register i is at BASE_ADDR+REG_OFFS+4*i
- BACKOFF, 16, idle cycles between ACQUIRE retries (≥1)
- MAX_RETRY, 255, ACQUIRE attempts before error (≥1)
- MASTER_ID, 0, constant driven on periph_id_o

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle job request; honoured only in IDLE
- params_i  in  N_PARAMS×32  job register values; sampled in the start cycle
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on job completion
- error_o  out  1  one-cycle pulse on retry exhaustion or r_id mismatch
- job_id_o  out  8  job id returned by ACQUIRE; held until the next acquire
- periph_req_o  out  1  request
- periph_gnt_i  in  1  grant
- periph_add_o  out  32  byte address
- periph_wen_o  out  1  1 = read, 0 = write
- periph_be_o  out  4  byte enable; always 4'hF
- periph_data_o  out  32  write data
- periph_id_o  out  ID_WIDTH  transaction id
- periph_r_valid_i  in  1  response valid
- periph_r_data_i  in  32  read data
- periph_r_id_i  in  ID_WIDTH  response id
- evt_i  in  1  HWPE end-of-job event, one-cycle pulse

## Operation
- States: IDLE, ACQ_REQ, ACQ_RSP, BACKOFF, WR_REQ, WR_RSP, TRIG_REQ, TRIG_RSP, WAIT_EVT, DONE.
- IDLE: on `start_i`, latch params_i, clear retry_cnt and evt_seen, then go to ACQ_REQ.
- ACQ_REQ: issue a read of BASE_ADDR+0x04. On gnt, go to ACQ_RSP.
- ACQ_RSP: on r_valid:
  - If r_data[31]=1 (no context free): retry_cnt++. If retry_cnt reaches MAX_RETRY, pulse error_o and return to IDLE. Otherwise go to BACKOFF.
  - If r_data[31]=0: job_id_o←r_data[7:0], idx←0, go to WR_REQ.
- BACKOFF: count BACKOFF cycles, then go to ACQ_REQ.
- WR_REQ: issue a write of params[idx] to BASE_ADDR+REG_OFFS+4·idx. On gnt, go to WR_RSP.
- WR_RSP: on r_valid, if idx=N_PARAMS-1 go to TRIG_REQ. Otherwise idx++ and go to WR_REQ.
- TRIG_REQ: issue a write of 32'h0 to BASE_ADDR+0x00. On gnt, go to TRIG_RSP.
- TRIG_RSP: on r_valid, go to WAIT_EVT.
- WAIT_EVT: when evt_i or evt_seen, go to DONE.
- DONE: pulse done_o, then go to IDLE.
- evt_seen is set by evt_i in TRIG_REQ, TRIG_RSP or WAIT_EVT, so an early event is never lost. evt_i is ignored in all other states.
- Any r_valid with r_id≠MASTER_ID pulses error_o and returns to IDLE. The slot is not released.
- start_i outside IDLE is ignored. params_i changes after the start cycle have no effect.
- Address arithmetic is 32-bit unsigned modulo 2^32.

## Timing
- Reset values: req=0, add=0, wen=1, be=4'hF, data=0, id=MASTER_ID, busy=0, done=0, error=0, job_id=0, state=IDLE.
- All outputs are registered or decoded from the state register only; there is no combinational path from any periph input to periph_req_o.
- Address phase:
  - req, add, wen and data are stable from assertion until the cycle gnt=1.
  - req drops the cycle after the grant.
  - Only one transaction is outstanding.
  - Write responses are awaited, like read responses.
- A response arriving in the same cycle as the grant is not legal from the slave and is not handled.
- With gnt tied high and r_valid one cycle after gnt:
  - ACQUIRE takes 2 cycles, each write 2 cycles.
  - start (cycle 0) → first req in cycle 1.
  - TRIGGER req in cycle 3+2·N_PARAMS.
  - WAIT_EVT is entered in cycle 5+2·N_PARAMS.
  - done_o fires 2 cycles after evt_i, provided evt_i occurs in or after WAIT_EVT.
- Reset asserted mid-transaction clears req asynchronously. Pending responses are dropped.

## Test plan
- Nominal job: gnt tied high, r_valid at +1, ACQUIRE returns 0x00000003, params 0x11..0x88, evt_i 10 cycles after TRIGGER. Required: job_id_o=3; writes to 0x40..0x5C in order with the matching data; write of 0 to 0x00; done_o exactly once; busy_o low afterwards.
- Busy slave: ACQUIRE returns 0xFFFFFFFF twice, then 0x1. Required: three reads of 0x04 separated by BACKOFF idle cycles; job proceeds with job_id_o=1.
- Retry exhaustion: MAX_RETRY=3, ACQUIRE always returns 0xFFFFFFFF. Required: exactly 3 reads, one error_o pulse, no writes, return to IDLE.
- Grant stalls: gnt random with 30 % probability, r_valid delay 1–4 cycles. Required: req, add and data stable until granted; never two outstanding transactions; same write sequence as the nominal job.
- Early event and bad id: evt_i pulses in the TRIG_RSP cycle → done_o is still produced. In a separate job, r_id=MASTER_ID+1 on ACQUIRE → error_o pulses and state returns to IDLE.
- Reset mid-write: deassert rst_ni during the WR_RSP of idx 4. Required: req=0 and busy_o=0 immediately; a new start_i runs a full job.
